// File: rtl/adi2axis_pkg.sv
// rtl/adi2axis_pkg.sv - shared encodings for the ADC-to-AXI-Stream capture block
package adi2axis_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    TRIG_IMM      = 2'd0,
    TRIG_EDGE     = 2'd1,
    TRIG_SYNC     = 2'd2,
    TRIG_IMM_ALT  = 2'd3
  } trig_mode_e;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_CONT     = 3;
  localparam int CTRL_MASK_LSB = 8;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_OVF      = 1;
  localparam int STAT_ARMED    = 2;
  localparam int STAT_CAPT     = 3;
  localparam int STAT_PKT_LSB  = 16;

endpackage

// File: rtl/adi2axis_mc_if.sv
// rtl/adi2axis_mc_if.sv - AXI-Stream beat bundle between buffer and stream port
interface adi2axis_mc_if #(
  parameter int DW = 64,
  parameter int SW = 8
);
  logic          tvalid;
  logic [DW-1:0] tdata;
  logic [SW-1:0] tstrb;
  logic          tlast;
  logic          tready;

  modport master (output tvalid, tdata, tstrb, tlast, input tready);
  modport slave  (input tvalid, tdata, tstrb, tlast, output tready);
endinterface

// File: rtl/adi2axis_fifo.sv
// rtl/adi2axis_fifo.sv - single-clock first-word-fall-through beat buffer
module adi2axis_fifo #(
  parameter int DATA_W = 64,
  parameter int STRB_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [STRB_W-1:0] wr_strb,
  input  logic              wr_last,
  output logic              full,
  output logic              empty,
  adi2axis_mc_if.master     rd
);
  localparam int AW = $clog2(DEPTH);
  localparam int W  = DATA_W + STRB_W + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push, pop;

  // Count never exceeds DEPTH (a power of 2), so its MSB alone flags full.
  assign full  = cnt_q[AW];
  assign empty = (cnt_q == '0);
  assign push  = wr_en && !full;
  assign pop   = !empty && rd.tready;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (push) wp_d = wp_q + AW'(1);
    if (pop)  rp_d = rp_q + AW'(1);
    if (push && !pop)      cnt_d = cnt_q + (AW+1)'(1);
    else if (pop && !push) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp_q] <= {wr_last, wr_strb, wr_data};
  end

  // Gate the head entry so the stream reads all-zero whenever nothing is buffered.
  assign rd.tvalid = !empty;
  assign {rd.tlast, rd.tstrb, rd.tdata} = empty ? '0 : mem[rp_q];

endmodule

// File: rtl/adi2axis_mc.sv
// rtl/adi2axis_mc.sv - multichannel sample capture with trigger FSM feeding an AXI-Stream master
module adi2axis_mc
  import adi2axis_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int CH_BYTES    = 4,
  parameter int FIFO_DEPTH  = 16,
  localparam int BEAT_BYTES = NUM_CH * CH_BYTES
) (
  input  logic                    AXIS_ACLK,
  input  logic                    AXIS_ARESETN,
  input  logic [31:0]             ctrl,
  input  logic [31:0]             xfer_beats,
  input  logic                    ovf_clr,
  output logic [31:0]             stat,
  input  logic [BEAT_BYTES*8-1:0] ddata,
  input  logic                    dvalid,
  input  logic                    dsync,
  input  logic                    trig,
  output logic                    ovf,
  output logic                    M_AXIS_TVALID,
  output logic [BEAT_BYTES*8-1:0] M_AXIS_TDATA,
  output logic [BEAT_BYTES-1:0]   M_AXIS_TSTRB,
  output logic                    M_AXIS_TLAST,
  input  logic                    M_AXIS_TREADY
);
  adi2axis_mc_if #(.DW(BEAT_BYTES*8), .SW(BEAT_BYTES)) axis_bus ();

  state_e                  state_q, state_d;
  trig_mode_e              mode_q, mode_d;
  logic [NUM_CH-1:0]       mask_q, mask_d;
  logic [31:0]             len_q, len_d, beat_q, beat_d;
  logic                    trig_q, trig_d;
  logic                    ovf_q, ovf_d, sticky_q, sticky_d;
  logic [15:0]             pkt_q, pkt_d;
  logic                    cap, drop, wr_en, wr_last, fifo_full, fifo_empty;
  logic [BEAT_BYTES*8-1:0] wr_data;
  logic [BEAT_BYTES-1:0]   wr_strb;
  logic                    unused_ctrl;

  assign unused_ctrl = ^{ctrl[31:CTRL_MASK_LSB+NUM_CH], ctrl[7:4]};

  always_comb begin
    wr_data = '0;
    wr_strb = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wr_data[c*CH_BYTES*8 +: CH_BYTES*8] = mask_q[c] ? ddata[c*CH_BYTES*8 +: CH_BYTES*8] : '0;
      wr_strb[c*CH_BYTES +: CH_BYTES]     = {CH_BYTES{mask_q[c]}};
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    mask_d  = mask_q;
    len_d   = len_q;
    beat_d  = beat_q;
    trig_d  = trig;
    cap     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ctrl[CTRL_EN] && xfer_beats != 32'd0) begin
          state_d = ST_ARMED;
          mode_d  = trig_mode_e'(ctrl[CTRL_MODE_LSB +: 2]);
          mask_d  = ctrl[CTRL_MASK_LSB +: NUM_CH];
          len_d   = xfer_beats;
          beat_d  = '0;
        end
      end
      ST_ARMED: begin
        if (!ctrl[CTRL_EN]) begin
          state_d = ST_IDLE;
        end else begin
          case (mode_q)
            TRIG_EDGE: if (trig && !trig_q) state_d = ST_CAPTURE;
            // The sync-marked sample itself is the first beat of the packet.
            TRIG_SYNC: if (dvalid && dsync) begin
              state_d = ST_CAPTURE;
              cap     = 1'b1;
            end
            default:   state_d = ST_CAPTURE;
          endcase
        end
      end
      ST_CAPTURE: cap = dvalid;
      default:    state_d = ST_IDLE;
    endcase

    wr_en   = cap && !fifo_full;
    drop    = cap && fifo_full;
    wr_last = (beat_q == len_q - 32'd1);
    if (wr_en) begin
      if (wr_last) begin
        beat_d  = '0;
        state_d = (ctrl[CTRL_CONT] && ctrl[CTRL_EN]) ? ST_ARMED : ST_IDLE;
      end else begin
        beat_d  = beat_q + 32'd1;
      end
    end

    ovf_d    = drop;
    sticky_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : sticky_q);
    pkt_d    = pkt_q;
    if (M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST) pkt_d = pkt_q + 16'd1;
  end

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_q  <= ST_IDLE;
      mode_q   <= TRIG_IMM;
      mask_q   <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      trig_q   <= 1'b0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
      pkt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      mask_q   <= mask_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      trig_q   <= trig_d;
      ovf_q    <= ovf_d;
      sticky_q <= sticky_d;
      pkt_q    <= pkt_d;
    end
  end

  adi2axis_fifo #(
    .DATA_W (BEAT_BYTES*8),
    .STRB_W (BEAT_BYTES),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (AXIS_ACLK),
    .rst_n   (AXIS_ARESETN),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .wr_last (wr_last),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .rd      (axis_bus)
  );

  assign axis_bus.tready = M_AXIS_TREADY;
  assign M_AXIS_TVALID   = axis_bus.tvalid;
  assign M_AXIS_TDATA    = axis_bus.tdata;
  assign M_AXIS_TSTRB    = axis_bus.tstrb;
  assign M_AXIS_TLAST    = axis_bus.tlast;
  assign ovf             = ovf_q;

  always_comb begin
    stat                         = '0;
    stat[STAT_BUSY]              = (state_q != ST_IDLE) || !fifo_empty;
    stat[STAT_OVF]               = sticky_q;
    stat[STAT_ARMED]             = (state_q == ST_ARMED);
    stat[STAT_CAPT]              = (state_q == ST_CAPTURE);
    stat[STAT_PKT_LSB +: 16]     = pkt_q;
  end

endmodule

// File: tb/tb_adi2axis_mc.sv
// tb/tb_adi2axis_mc.sv - directed self-checking bench for adi2axis_mc
module tb_adi2axis_mc;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ctrl = '0;
  logic [31:0] xfer_beats = '0;
  logic        ovf_clr = 1'b0;
  logic [31:0] stat;
  logic [63:0] ddata = '0;
  logic        dvalid = 1'b0;
  logic        dsync = 1'b0;
  logic        trig = 1'b0;
  logic        ovf;

  adi2axis_mc_if #(.DW(64), .SW(8)) axis ();

  int          vectors = 0;
  int          miscompares = 0;
  int          ovf_cnt = 0;
  int          base;
  int          ovf_base;
  logic [72:0] beats[$];

  always #5 clk = ~clk;

  adi2axis_mc #(.NUM_CH(2), .CH_BYTES(4), .FIFO_DEPTH(16)) dut (
    .AXIS_ACLK     (clk),
    .AXIS_ARESETN  (rst_n),
    .ctrl          (ctrl),
    .xfer_beats    (xfer_beats),
    .ovf_clr       (ovf_clr),
    .stat          (stat),
    .ddata         (ddata),
    .dvalid        (dvalid),
    .dsync         (dsync),
    .trig          (trig),
    .ovf           (ovf),
    .M_AXIS_TVALID (axis.tvalid),
    .M_AXIS_TDATA  (axis.tdata),
    .M_AXIS_TSTRB  (axis.tstrb),
    .M_AXIS_TLAST  (axis.tlast),
    .M_AXIS_TREADY (axis.tready)
  );

  always @(negedge clk) begin
    if (axis.tvalid && axis.tready) beats.push_back({axis.tlast, axis.tstrb, axis.tdata});
    if (ovf) ovf_cnt++;
  end

  function automatic logic [63:0] mk(input int n);
    return {32'hB000_0000 + 32'(n), 32'hA000_0000 + 32'(n)};
  endfunction

  function automatic logic [72:0] bt(input logic l, input logic [7:0] s, input logic [63:0] d);
    return {l, s, d};
  endfunction

  task automatic check(input string tag, input logic [72:0] obs, input logic [72:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic v, input logic s, input logic t, input logic [63:0] d);
    dvalid = v;
    dsync  = s;
    trig   = t;
    ddata  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tvalid"}, 73'(axis.tvalid), 73'(0));
    check({tag, "_tlast"},  73'(axis.tlast),  73'(0));
    check({tag, "_tdata"},  73'(axis.tdata),  73'(0));
    check({tag, "_tstrb"},  73'(axis.tstrb),  73'(0));
    check({tag, "_ovf"},    73'(ovf),         73'(0));
    check({tag, "_stat"},   73'(stat),        73'(0));
  endtask

  initial begin
    axis.tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    idle(2);

    // Mode 0, 8 beats; enable dropped mid-packet must not truncate
    base = beats.size(); ovf_base = ovf_cnt;
    ctrl = 32'h301; xfer_beats = 32'd8;
    idle(3);
    check("t1_capturing", 73'(stat), 73'(32'h0000_0009));
    for (int i = 0; i < 10; i++) begin
      if (i == 3) ctrl = 32'h0;
      tick(1'b1, 1'b0, 1'b0, mk(i));
    end
    idle(4);
    check("t1_size", 73'(beats.size() - base), 73'(8));
    for (int k = 0; k < 8; k++)
      check($sformatf("t1_beat%0d", k), beats[base+k], bt(k == 7, 8'hFF, mk(k)));
    check("t1_stat", 73'(stat), 73'(32'h0001_0000));
    check("t1_no_ovf", 73'(ovf_cnt - ovf_base), 73'(0));

    // Mode 1: trig pulse at cycle 20, capture begins with cycle 21's sample
    base = beats.size();
    ctrl = 32'h303;
    for (int c = 0; c < 30; c++) begin
      if (c == 22) ctrl = 32'h0;
      tick(1'b1, 1'b0, c == 20, mk(100 + c));
      if (c == 19) begin
        check("t2_nothing_early", 73'(beats.size() - base), 73'(0));
        check("t2_armed", 73'(stat), 73'(32'h0001_0005));
      end
    end
    idle(4);
    check("t2_size", 73'(beats.size() - base), 73'(8));
    check("t2_first", beats[base], bt(1'b0, 8'hFF, mk(121)));
    check("t2_last", beats[base+7], bt(1'b1, 8'hFF, mk(128)));
    check("t2_stat", 73'(stat), 73'(32'h0002_0000));

    // Mode 2 continuous: dsync on 3rd valid sample, then a second packet on the next dsync
    base = beats.size(); ovf_base = ovf_cnt;
    ctrl = 32'h30D;
    idle(1);
    for (int i = 0; i < 22; i++) begin
      if (i == 15) ctrl = 32'h0;
      tick(1'b1, (i == 2) || (i == 5) || (i == 12), 1'b0, mk(200 + i));
      if (i == 1) begin
        check("t3_wait_sync", 73'(beats.size() - base), 73'(0));
        check("t3_armed", 73'(stat), 73'(32'h0002_0005));
      end
    end
    idle(4);
    check("t3_size", 73'(beats.size() - base), 73'(16));
    for (int k = 0; k < 16; k++)
      check($sformatf("t3_beat%0d", k), beats[base+k],
            bt(k == 7 || k == 15, 8'hFF, (k < 8) ? mk(202 + k) : mk(212 + k - 8)));
    check("t3_stat", 73'(stat), 73'(32'h0004_0000));
    check("t3_no_ovf", 73'(ovf_cnt - ovf_base), 73'(0));

    // Overflow: TREADY low, 20 samples into a 16-deep buffer; clear coincides with a drop
    base = beats.size(); ovf_base = ovf_cnt;
    axis.tready = 1'b0;
    ctrl = 32'h301; xfer_beats = 32'd32;
    idle(3);
    for (int i = 0; i < 20; i++) begin
      ovf_clr = (i == 19);
      tick(1'b1, 1'b0, 1'b0, mk(300 + i));
    end
    ovf_clr = 1'b0;
    idle(2);
    check("t4_ovf_pulses", 73'(ovf_cnt - ovf_base), 73'(4));
    check("t4_stat_full", 73'(stat), 73'(32'h0004_000B));
    check("t4_held", 73'(beats.size() - base), 73'(0));
    ctrl = 32'h0;
    axis.tready = 1'b1;
    idle(2);
    for (int i = 0; i < 16; i++) tick(1'b1, 1'b0, 1'b0, mk(400 + i));
    idle(20);
    check("t4_size", 73'(beats.size() - base), 73'(32));
    check("t4_beat0", beats[base], bt(1'b0, 8'hFF, mk(300)));
    check("t4_beat15", beats[base+15], bt(1'b0, 8'hFF, mk(315)));
    check("t4_beat16", beats[base+16], bt(1'b0, 8'hFF, mk(400)));
    check("t4_beat30", beats[base+30], bt(1'b0, 8'hFF, mk(414)));
    check("t4_beat31", beats[base+31], bt(1'b1, 8'hFF, mk(415)));
    check("t4_ovf_total", 73'(ovf_cnt - ovf_base), 73'(4));
    check("t4_sticky", 73'(stat), 73'(32'h0005_0002));
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    check("t4_cleared", 73'(stat), 73'(32'h0005_0000));

    // Channel mask 01: upper lanes zero with TSTRB 0F
    base = beats.size();
    ctrl = 32'h101; xfer_beats = 32'd2;
    idle(3);
    tick(1'b1, 1'b0, 1'b0, mk(500));
    ctrl = 32'h0;
    tick(1'b1, 1'b0, 1'b0, mk(501));
    idle(4);
    check("t5_size", 73'(beats.size() - base), 73'(2));
    check("t5_beat0", beats[base], bt(1'b0, 8'h0F, 64'h0000_0000_A000_01F4));
    check("t5_beat1", beats[base+1], bt(1'b1, 8'h0F, 64'h0000_0000_A000_01F5));
    check("t5_stat", 73'(stat), 73'(32'h0006_0000));

    // Reset at beat 3 of 8, then a fresh full packet
    ctrl = 32'h301; xfer_beats = 32'd8;
    idle(3);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, mk(600 + i));
    rst_n = 1'b0;
    ctrl = 32'h0;
    #2;
    check_reset_outputs("t6_rst");
    idle(2);
    rst_n = 1'b1;
    base = beats.size();
    idle(4);
    check("t6_no_partial", 73'(beats.size() - base), 73'(0));
    ctrl = 32'h301;
    idle(3);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) ctrl = 32'h0;
      tick(1'b1, 1'b0, 1'b0, mk(700 + i));
    end
    idle(4);
    check("t6_size", 73'(beats.size() - base), 73'(8));
    check("t6_first", beats[base], bt(1'b0, 8'hFF, mk(700)));
    check("t6_last", beats[base+7], bt(1'b1, 8'hFF, mk(707)));
    check("t6_stat", 73'(stat), 73'(32'h0001_0000));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adi2axis_mc.md
ADI2AXIS_MC -- requirements
Module: adi2axis_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of sample channels (1..4).
REQ-002 SHALL have parameter CH_BYTES, default 4, bytes per channel sample.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, output buffer entries (power of 2, >=4); BEAT_BYTES = NUM_CH*CH_BYTES.
REQ-004 SHALL have ports: AXIS_ACLK in 1 clock; AXIS_ARESETN in 1 reset. One clock; reset is asynchronous and active-low.
REQ-005 SHALL have ports: ctrl in 32 control word; xfer_beats in 32 packet length in beats; ovf_clr in 1 sticky-overflow clear; stat out 32 status.
REQ-006 SHALL have ports: ddata in BEAT_BYTES*8 sample data; dvalid in 1; dsync in 1 frame marker; trig in 1 external trigger; ovf out 1 drop pulse.
REQ-007 SHALL have ports: M_AXIS_TVALID out 1; M_AXIS_TDATA out BEAT_BYTES*8; M_AXIS_TSTRB out BEAT_BYTES; M_AXIS_TLAST out 1; M_AXIS_TREADY in 1.

Function
REQ-008 ctrl SHALL decode: [0] enable, [2:1] trigger mode (0 immediate, 1 trig rising edge, 2 dsync, 3 = immediate), [3] continuous, [8+NUM_CH-1:8] channel mask.
REQ-009 FSM SHALL have states IDLE, ARMED, CAPTURE.
REQ-010 IDLE->ARMED when enable=1 and xfer_beats!=0; mode, mask, xfer_beats latched on this transition.
REQ-011 ARMED->CAPTURE: mode 0 next cycle; mode 1 cycle after trig=1 with trig registered low; mode 2 on dvalid&dsync, that sample being the first captured.
REQ-012 In CAPTURE each dvalid with FIFO not full SHALL write one beat and increment beat counter; dsync ignored.
REQ-013 Beat with counter = latched xfer_beats-1 SHALL be written with last=1; CAPTURE then goes ARMED if continuous&enable, else IDLE.
REQ-014 Clearing enable mid-packet SHALL NOT truncate; current packet completes, then IDLE.
REQ-015 dvalid in CAPTURE with FIFO full SHALL drop the sample, not count it, pulse ovf high one cycle, set stat[1].
REQ-016 dvalid outside CAPTURE SHALL be discarded silently (no ovf).
REQ-017 Disabled-mask channel lanes SHALL output TDATA zero and TSTRB zero; enabled lanes TSTRB all ones.
REQ-018 FIFO SHALL be first-word-fall-through: beat written cycle t visible on M_AXIS_TVALID cycle t+1; sustain one beat/cycle with TREADY=1.
REQ-019 TVALID SHALL hold with TDATA/TSTRB/TLAST stable until TREADY; simultaneous write and read on full FIFO SHALL count as full (drop).
REQ-020 stat SHALL be: [0] busy (state!=IDLE or FIFO non-empty), [1] sticky overflow, [2] armed, [3] capturing, [15:4] zero, [31:16] completed-packet count (TLAST handshakes), wrapping 65535->0.
REQ-021 ovf_clr SHALL clear stat[1]; simultaneous new drop SHALL win (bit stays 1).

Reset
REQ-022 Reset SHALL force IDLE, FIFO empty, beat counter 0, packet count 0, stat[1] 0.
REQ-023 During reset outputs SHALL be: M_AXIS_TVALID 0, M_AXIS_TLAST 0, M_AXIS_TDATA 0, M_AXIS_TSTRB 0, ovf 0, stat 0.
REQ-024 Reset mid-packet SHALL discard buffered beats; no partial packet emitted after release.

Structure
REQ-025 Package adi2axis_pkg SHALL hold FSM state encoding, ctrl bit indices, trigger-mode codes, stat bit indices.
REQ-026 Buffer SHALL be sub-module adi2axis_fifo: single-clock FWFT FIFO, width BEAT_BYTES*8+BEAT_BYTES+1, depth FIFO_DEPTH.

Verification
REQ-027 NUM_CH=2, mode 0, xfer_beats=8, dvalid continuous, TREADY=1 -> 8 beats, TLAST on 8th only, stat[31:16]=1, IDLE after.
REQ-028 Mode 1, trig pulse at cycle 20, dvalid constant -> first TDATA equals sample at cycle 21; nothing captured before.
REQ-029 Mode 2, dsync on 3rd valid sample -> first beat is that sample; continuous=1 yields back-to-back packets each 8 beats.
REQ-030 TREADY=0, FIFO_DEPTH=16, 20 valid samples, xfer_beats=32 -> 4 ovf pulses, stat[1]=1; after TREADY=1 32 beats total, ovf_clr clears stat[1].
REQ-031 mask=2'b01 -> upper CH_BYTES lanes TDATA 0, TSTRB=8'h0F.
REQ-032 AXIS_ARESETN low at beat 3 of 8 -> TVALID 0 in reset, stat 0, next packet starts fresh with full 8 beats.
